// File: rtl/pipeline_stall_ctrl.sv
// Central sequencer for the 5-stage core. It produces the enables, flushes and bubble for the pipeline registers.
// It resolves load-use hazards, taken-branch flushes and data-memory waits, and latches a timeout fault.
module pipeline_stall_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_ex_mem_read,
  input  logic [4:0]       id_ex_rd,
  input  logic [4:0]       if_id_rs1,
  input  logic [4:0]       if_id_rs2,
  input  logic             branch_taken,
  input  logic             ex_mem_mem_access,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             pipe_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             mem_wb_bubble,
  output logic             dmem_req,
  output logic             fault,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_WAIT  = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    M_NORMAL  = 3'd0,
    M_FREEZE  = 3'd1,
    M_BRANCH  = 3'd2,
    M_LOADUSE = 3'd3,
    M_HALT    = 3'd4
  } mode_t;

  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

  state_t     state;
  state_t     state_next;
  logic [7:0] wait_cnt;
  logic [7:0] wait_next;
  mode_t      mode;
  mode_t      release_mode;
  logic       hazard;

  assign hazard = id_ex_mem_read && (id_ex_rd != 5'd0) &&
                  ((id_ex_rd == if_id_rs1) || (id_ex_rd == if_id_rs2));

  // A branch flushes the dependent instruction, so it masks any coincident hazard.
  assign release_mode = branch_taken ? M_BRANCH : (hazard ? M_LOADUSE : M_NORMAL);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_RUN;
      wait_cnt <= 8'd0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_next;
    end
  end

  always_comb begin
    state_next = state;
    wait_next  = wait_cnt;
    mode       = M_NORMAL;
    case (state)
      S_RUN: begin
        if (ex_mem_mem_access && !dmem_ready) begin
          mode       = M_FREEZE;
          state_next = S_WAIT;
          wait_next  = 8'd1;
        end else begin
          mode = release_mode;
        end
      end
      S_WAIT: begin
        // Ready wins over the timeout when both land in the same cycle.
        if (dmem_ready) begin
          mode       = release_mode;
          state_next = S_RUN;
          wait_next  = 8'd0;
        end else if (wait_cnt == TIMEOUT) begin
          mode       = M_FREEZE;
          state_next = S_FAULT;
        end else begin
          mode      = M_FREEZE;
          wait_next = wait_cnt + 8'd1;
        end
      end
      S_FAULT: begin
        mode = M_HALT;
      end
      default: begin
        mode       = M_HALT;
        state_next = S_RUN;
        wait_next  = 8'd0;
      end
    endcase
    if (!reset) begin
      mode = M_HALT;
    end
  end

  always_comb begin
    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    pipe_en       = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_flush  = 1'b0;
    mem_wb_bubble = 1'b0;
    case (mode)
      M_FREEZE: begin
        pc_en         = 1'b0;
        if_id_en      = 1'b0;
        pipe_en       = 1'b0;
        mem_wb_bubble = 1'b1;
      end
      M_BRANCH: begin
        if_id_flush  = 1'b1;
        id_ex_flush  = 1'b1;
        ex_mem_flush = 1'b1;
      end
      M_LOADUSE: begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_flush = 1'b1;
      end
      M_HALT: begin
        pc_en         = 1'b0;
        if_id_en      = 1'b0;
        pipe_en       = 1'b0;
        if_id_flush   = 1'b1;
        id_ex_flush   = 1'b1;
        ex_mem_flush  = 1'b1;
        mem_wb_bubble = 1'b1;
      end
      default: ;
    endcase
  end

  assign dmem_req = reset && (state != S_FAULT) && ex_mem_mem_access;
  assign fault    = reset && (state == S_FAULT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_count <= '0;
    end else if ((state != S_FAULT) && !pc_en && (stall_count != '1)) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Self-checking bench for pipeline_stall_ctrl: instance A (timeout 15, 4-bit counter) and instance B (timeout 3).
// Both instances share their inputs. Expected values go into a scoreboard queue and are checked mid-cycle.
module tb_pipeline_stall_ctrl;

  localparam logic [8:0] NORMAL  = 9'b111_000_0_0_0;
  localparam logic [8:0] FREEZE  = 9'b000_000_1_0_0;
  localparam logic [8:0] BRANCH  = 9'b111_111_0_0_0;
  localparam logic [8:0] LOADUSE = 9'b001_010_0_0_0;
  localparam logic [8:0] FAULTM  = 9'b000_111_1_0_1;
  localparam logic [8:0] RSTM    = 9'b000_111_1_0_0;
  localparam logic [8:0] REQ     = 9'b000_000_0_1_0;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       id_ex_mem_read = 1'b0;
  logic [4:0] id_ex_rd = 5'd0;
  logic [4:0] if_id_rs1 = 5'd0;
  logic [4:0] if_id_rs2 = 5'd0;
  logic       branch_taken = 1'b0;
  logic       ex_mem_mem_access = 1'b0;
  logic       dmem_ready = 1'b0;

  logic        pc_en_a, if_id_en_a, pipe_en_a, if_id_flush_a, id_ex_flush_a, ex_mem_flush_a;
  logic        mem_wb_bubble_a, dmem_req_a, fault_a;
  logic [3:0]  cnt_a;
  logic        pc_en_b, if_id_en_b, pipe_en_b, if_id_flush_b, id_ex_flush_b, ex_mem_flush_b;
  logic        mem_wb_bubble_b, dmem_req_b, fault_b;
  logic [15:0] cnt_b;
  logic [8:0]  ctrl_a, ctrl_b;

  assign ctrl_a = {pc_en_a, if_id_en_a, pipe_en_a, if_id_flush_a, id_ex_flush_a, ex_mem_flush_a,
                   mem_wb_bubble_a, dmem_req_a, fault_a};
  assign ctrl_b = {pc_en_b, if_id_en_b, pipe_en_b, if_id_flush_b, id_ex_flush_b, ex_mem_flush_b,
                   mem_wb_bubble_b, dmem_req_b, fault_b};

  pipeline_stall_ctrl #(.MEM_TIMEOUT(15), .CNT_W(4)) dut_a (
    .clk(clk), .reset(reset), .id_ex_mem_read(id_ex_mem_read), .id_ex_rd(id_ex_rd),
    .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2), .branch_taken(branch_taken),
    .ex_mem_mem_access(ex_mem_mem_access), .dmem_ready(dmem_ready),
    .pc_en(pc_en_a), .if_id_en(if_id_en_a), .pipe_en(pipe_en_a), .if_id_flush(if_id_flush_a),
    .id_ex_flush(id_ex_flush_a), .ex_mem_flush(ex_mem_flush_a), .mem_wb_bubble(mem_wb_bubble_a),
    .dmem_req(dmem_req_a), .fault(fault_a), .stall_count(cnt_a)
  );

  pipeline_stall_ctrl #(.MEM_TIMEOUT(3), .CNT_W(16)) dut_b (
    .clk(clk), .reset(reset), .id_ex_mem_read(id_ex_mem_read), .id_ex_rd(id_ex_rd),
    .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2), .branch_taken(branch_taken),
    .ex_mem_mem_access(ex_mem_mem_access), .dmem_ready(dmem_ready),
    .pc_en(pc_en_b), .if_id_en(if_id_en_b), .pipe_en(pipe_en_b), .if_id_flush(if_id_flush_b),
    .id_ex_flush(id_ex_flush_b), .ex_mem_flush(ex_mem_flush_b), .mem_wb_bubble(mem_wb_bubble_b),
    .dmem_req(dmem_req_b), .fault(fault_b), .stall_count(cnt_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        mem_read;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        br;
    logic        acc;
    logic        rdy;
    logic [8:0]  ctrl;
    logic [15:0] cnt;
    logic        sel;
  } vec_t;

  typedef struct {
    string       name;
    logic        sel;
    logic [8:0]  ctrl;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(input string name, input logic mr, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2, input logic br,
                              input logic acc, input logic rdy, input logic [8:0] ctrl,
                              input logic [15:0] cnt, input logic sel = 1'b0);
    vec_t v;
    v.name = name; v.mem_read = mr; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
    v.br = br; v.acc = acc; v.rdy = rdy; v.ctrl = ctrl; v.cnt = cnt; v.sel = sel;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    exp_t e;
    id_ex_mem_read    = v.mem_read;
    id_ex_rd          = v.rd;
    if_id_rs1         = v.rs1;
    if_id_rs2         = v.rs2;
    branch_taken      = v.br;
    ex_mem_mem_access = v.acc;
    dmem_ready        = v.rdy;
    e.name = v.name; e.sel = v.sel; e.ctrl = v.ctrl; e.cnt = v.cnt;
    sb.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t        e;
    logic [8:0]  act;
    logic [15:0] act_cnt;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard_empty: no expected entry queued");
      return;
    end
    e       = sb.pop_front();
    act     = e.sel ? ctrl_b : ctrl_a;
    act_cnt = e.sel ? cnt_b : {12'd0, cnt_a};
    checks++;
    if (act !== e.ctrl) begin
      errors++;
      $display("[TB] FAIL %s ctrl(dut_%s) got=%b expected=%b", e.name, e.sel ? "b" : "a", act, e.ctrl);
    end
    checks++;
    if (act_cnt !== e.cnt) begin
      errors++;
      $display("[TB] FAIL %s stall_count(dut_%s) got=%0d expected=%0d", e.name, e.sel ? "b" : "a",
               act_cnt, e.cnt);
    end
  endtask

  task automatic runVec(input vec_t v);
    applyStimulus(v);
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    #1;
  endtask

  // Access is driven high during reset to show dmem_req is still forced low.
  task automatic doReset(input int n, input logic sel);
    reset = 1'b0;
    for (int i = 0; i < n; i++) runVec(mk("reset", 0, 0, 0, 0, 0, 1, 0, RSTM, 0, sel));
    reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    tbl.push_back(mk("idle",               0, 0, 0, 0, 0, 0, 0, NORMAL, 0));
    tbl.push_back(mk("loaduse_rs2",        1, 5, 1, 5, 0, 0, 0, LOADUSE, 0));
    tbl.push_back(mk("after_loaduse",      0, 5, 1, 5, 0, 0, 0, NORMAL, 1));
    tbl.push_back(mk("rd0_no_stall",       1, 0, 0, 0, 0, 0, 0, NORMAL, 1));
    tbl.push_back(mk("loaduse_rs1",        1, 7, 7, 2, 0, 0, 0, LOADUSE, 1));
    tbl.push_back(mk("branch_over_hazard", 1, 7, 7, 2, 1, 0, 0, BRANCH, 2));
    tbl.push_back(mk("idle2",              0, 7, 7, 2, 0, 0, 0, NORMAL, 2));
    tbl.push_back(mk("no_match",           1, 9, 3, 4, 0, 0, 0, NORMAL, 2));
    tbl.push_back(mk("mem_ready_now",      0, 0, 0, 0, 0, 1, 1, NORMAL | REQ, 2));
    tbl.push_back(mk("wait_enter",         0, 0, 0, 0, 0, 1, 0, FREEZE | REQ, 2));
    tbl.push_back(mk("wait_1",             0, 0, 0, 0, 0, 1, 0, FREEZE | REQ, 3));
    tbl.push_back(mk("wait_2",             0, 0, 0, 0, 0, 1, 0, FREEZE | REQ, 4));
    tbl.push_back(mk("wait_3",             0, 0, 0, 0, 0, 1, 0, FREEZE | REQ, 5));
    tbl.push_back(mk("wait_release",       0, 0, 0, 0, 0, 1, 1, NORMAL | REQ, 6));
    tbl.push_back(mk("post_release",       0, 0, 0, 0, 0, 0, 0, NORMAL, 6));
    tbl.push_back(mk("br_wait_enter",      0, 0, 0, 0, 1, 1, 0, FREEZE | REQ, 6));
    tbl.push_back(mk("br_wait_frozen",     1, 3, 3, 0, 1, 1, 0, FREEZE | REQ, 7));
    tbl.push_back(mk("br_release",         1, 3, 3, 0, 1, 1, 1, BRANCH | REQ, 8));
    tbl.push_back(mk("post_br",            0, 0, 0, 0, 0, 0, 0, NORMAL, 8));
    tbl.push_back(mk("lu_wait_enter",      0, 0, 0, 0, 0, 1, 0, FREEZE | REQ, 8));
    tbl.push_back(mk("lu_release",         1, 4, 0, 4, 0, 1, 1, LOADUSE | REQ, 9));
    tbl.push_back(mk("post_lu",            0, 0, 0, 0, 0, 0, 0, NORMAL, 10));

    @(posedge clk);
    #1;
    doReset(3, 1'b0);
    foreach (tbl[i]) runVec(tbl[i]);

    // Twenty back-to-back load-use stalls saturate the 4-bit counter.
    doReset(1, 1'b0);
    for (int i = 0; i < 20; i++)
      runVec(mk("saturate", 1, 5, 5, 0, 0, 0, 0, LOADUSE, (i < 15) ? 16'(i) : 16'd15));
    runVec(mk("saturate_hold", 0, 0, 0, 0, 0, 0, 0, NORMAL, 15));

    // Reset mid-WAIT must drop wait_cnt, otherwise the timeout below would fire early.
    doReset(1, 1'b1);
    runVec(mk("midwait_enter", 0, 0, 0, 0, 0, 1, 0, FREEZE | REQ, 0, 1'b1));
    runVec(mk("midwait_1",     0, 0, 0, 0, 0, 1, 0, FREEZE | REQ, 1, 1'b1));
    doReset(1, 1'b1);
    for (int i = 0; i < 4; i++)
      runVec(mk("timeout_frozen", 0, 0, 0, 0, 0, 1, 0, FREEZE | REQ, 16'(i), 1'b1));
    for (int i = 0; i < 20; i++)
      runVec(mk("fault_held", 1, 2, 2, 0, (i % 3) == 0, 1, i >= 10, FAULTM, 4, 1'b1));
    doReset(1, 1'b1);

    for (int i = 0; i < 3; i++)
      runVec(mk("edge_frozen", 0, 0, 0, 0, 0, 1, 0, FREEZE | REQ, 16'(i), 1'b1));
    runVec(mk("edge_release", 0, 0, 0, 0, 0, 1, 1, NORMAL | REQ, 3, 1'b1));
    runVec(mk("edge_after",   0, 0, 0, 0, 0, 0, 0, NORMAL, 3, 1'b1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
